medidor_frecuencia: RTL
=======================

# medidor_frecuencia

Measures the frequency of an asynchronous pulse input, such as the infrared sensor output, by counting its rising edges over a fixed gate window timed from `clk_in`. It is the measuring counterpart of the clock divider: the divider synthesises a frequency from `clk_in`, and this block recovers an unknown frequency against `clk_in`. Each completed window publishes an edge count with a one-cycle `valid` strobe for the display and counter logic.

## Interface
- `CLK_IN_FREQ`, default 50_000_000: system clock frequency in Hz.
- `GATE_MS`, default 1000: gate window length in ms. With 1000, `freq_count` reads directly in Hz.
- `COUNT_W`, default 24: width of the edge counter and of `freq_count`.
- `FILTER_CYCLES`, default 4: stability length for the glitch filter. Only used when `GLITCH_FILTER_EN` is defined.
- `clk_in` in, 1 bit: system clock.
- `rst` in, 1 bit: reset, synchronous, active-high. Clock `clk_in`.
- `sig_in` in, 1 bit: asynchronous pulse input to measure.
- `enable` in, 1 bit: 1 = measure continuously, 0 = stop and abort.
- `freq_count` out, `COUNT_W` bits: rising-edge count of the last completed window.
- `valid` out, 1 bit: one-cycle pulse when `freq_count` updates.
- `overflow` out, 1 bit: the last completed window saturated.
- `busy` out, 1 bit: a window is in progress.

## Operation
- **Derived constant:** `GATE_CYCLES = CLK_IN_FREQ/1000*GATE_MS`.
  - Gate counter width is `$clog2(GATE_CYCLES)`.
  - An elaboration error is raised if `GATE_CYCLES < 2`.
- **Input conditioning:** `sig_in` passes through a 2-FF synchronizer, then the optional filter, then a rising-edge detector. The detector produces `edge_p`, a one-cycle pulse per 0→1 transition.
- **FSM state IDLE:**
  - `busy`=0 and both counters are cleared.
  - Goes to COUNT when `enable`=1.
- **FSM state COUNT:**
  - `busy`=1. The gate counter increments every cycle.
  - Each `edge_p` increments the edge counter, which saturates at 2^`COUNT_W`-1 and sets an internal saturation flag.
  - On the cycle where the gate counter equals `GATE_CYCLES`-1, go to LATCH.
- **FSM state LATCH (one cycle):**
  - `freq_count` takes the edge counter value, `overflow` takes the saturation flag, and `valid` pulses 1.
  - The gate counter, edge counter and saturation flag clear.
  - Next state is COUNT if `enable`=1, otherwise IDLE.
- **`enable` falls during COUNT:** go to IDLE on the next edge. There is no `valid` pulse, and `freq_count`/`overflow` keep their previous values.
- **Edge-count rules:**
  - An `edge_p` coinciding with the terminal gate cycle counts in the closing window.
  - An `edge_p` during LATCH counts as 1 in the new window, so no edges are lost between windows.
- **Input stuck high or low:** no edges are produced and `freq_count`=0 is reported.
- **Input above `CLK_IN_FREQ`/4:** unsupported. The result is undefined but saturation-safe.

## Timing
- **Reset values:** `freq_count`=0, `valid`=0, `overflow`=0, `busy`=0, FSM in IDLE, synchronizer flops 0.
- **Reset mid-window:** the window is discarded and every output returns to its reset value on the next edge.
- **Input latency:** `sig_in` rise to `edge_p` is 3 cycles, or 3+`FILTER_CYCLES` with the filter enabled.
- **Window timing:**
  - Each window is `GATE_CYCLES` cycles in COUNT plus 1 LATCH cycle, so in continuous mode `valid` repeats every `GATE_CYCLES`+1 cycles.
  - The first window begins the cycle after `enable` is sampled high in IDLE.
- **Output registers:** `freq_count` and `overflow` are registered and change only in the cycle `valid`=1. They are stable otherwise.

## Configuration
- **`GLITCH_FILTER_EN` defined:** a filter is inserted after the synchronizer.
  - The filtered level changes only after the synchronized input has held the new value for `FILTER_CYCLES` consecutive cycles.
  - Pulses shorter than that are dropped.
- **`GLITCH_FILTER_EN` undefined:** the synchronized signal feeds the edge detector directly, with no added latency. `FILTER_CYCLES` is ignored.

## Structure
- **Package `medidor_pkg`:**
  - FSM state enum (IDLE, COUNT, LATCH).
  - `GATE_CYCLES` calculation function.
  - Synchronizer depth constant, value 2.
- **Sub-module `acondicionador_entrada`:** contains the synchronizer, the optional filter and the edge detector, with output `edge_p`. The top level holds the FSM, the gate counter and the edge counter.

## Test plan
All cases use `CLK_IN_FREQ`=1_000_000, `GATE_MS`=1, so `GATE_CYCLES`=1000.
- **Nominal count:** `enable`=1, `sig_in` toggles every 10 cycles → `valid` every 1001 cycles with `freq_count`=50, `overflow`=0.
- **Saturation:** `COUNT_W`=4, `sig_in` toggles every 4 cycles (125 edges) → `freq_count`=15, `overflow`=1.
- **Abort:** `enable` drops at cycle 500 of the second window → no second `valid`, `freq_count` holds the first result, and `busy`=0 within 1 cycle.
- **Reset mid-window:** `rst` pulses at cycle 300 → all outputs 0 next cycle. With `enable` still 1, the window restarts and `valid` comes 1001 cycles after reset release.
- **Boundary edges:** edges placed on the terminal gate cycle and on the LATCH cycle → terminal edge counted in the old window, LATCH edge counted in the new window, total equals edges driven.
- **Filter (`GLITCH_FILTER_EN`, `FILTER_CYCLES`=4):** 2-cycle glitches are ignored and `freq_count`=0. 6-cycle pulses every 20 cycles give `freq_count`=50.

Source files
------------

// File: rtl/medidor_frecuencia_pkg.sv
// medidor_pkg: shared FSM states, synchronizer depth and gate-length helper for medidor_frecuencia.
package medidor_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

    localparam int SYNC_DEPTH = 2;

    function automatic int gate_cycles(input int clk_freq, input int gate_ms);
        return clk_freq / 1000 * gate_ms;
    endfunction

endpackage

// File: rtl/medidor_frecuencia_acondicionador_entrada.sv
// acondicionador_entrada: synchronizes sig_in, optionally deglitches it (GLITCH_FILTER_EN),
// and emits a registered one-cycle edge_p per rising edge.
module acondicionador_entrada
    import medidor_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic edge_p
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;
    logic                  w_level;

    if (FILTER_CYCLES < 1) begin : g_filter_chk
        $error("FILTER_CYCLES must be at least 1");
    end

    always_ff @(posedge clk_in) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_DEPTH-2:0], sig_in};
    end

`ifdef GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

    logic [FILT_W-1:0] r_cnt;
    logic              r_filt;

    // Level follows the input only after it has disagreed for FILTER_CYCLES straight cycles.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync[SYNC_DEPTH-1] == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == FILT_W'(FILTER_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync[SYNC_DEPTH-1];
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_DEPTH-1];
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_prev <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            r_prev <= w_level;
            edge_p <= w_level & ~r_prev;
        end
    end

endmodule

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: counts rising edges of sig_in over a GATE_MS window of clk_in and publishes
// the count with a valid strobe. Optional input deglitching via GLITCH_FILTER_EN.
module medidor_frecuencia
    import medidor_pkg::*;
#(
    parameter int CLK_IN_FREQ   = 50_000_000,
    parameter int GATE_MS       = 1000,
    parameter int COUNT_W       = 24,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] freq_count,
    output logic               valid,
    output logic               overflow,
    output logic               busy
);

    localparam int                 GATE_CYCLES = gate_cycles(CLK_IN_FREQ, GATE_MS);
    localparam int                 GATE_W      = (GATE_CYCLES < 2) ? 1 : $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

    if (GATE_CYCLES < 2) begin : g_gate_chk
        $error("GATE_CYCLES must be at least 2");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [GATE_W-1:0]  r_gate;
    logic [COUNT_W-1:0] r_edges;
    logic               r_sat;
    logic               w_edge_p;
    logic               w_last;

    acondicionador_entrada #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_acond (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .edge_p (w_edge_p)
    );

    assign w_last = r_gate == GATE_LAST;

    always_ff @(posedge clk_in) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Dropping enable aborts the window even on its terminal cycle.
    always_comb begin
        w_state_next = r_state;
        busy         = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_next = enable ? COUNT : IDLE;
            COUNT:   w_state_next = !enable ? IDLE : (w_last ? LATCH : COUNT);
            default: w_state_next = enable ? COUNT : IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_gate     <= '0;
            r_edges    <= '0;
            r_sat      <= 1'b0;
            freq_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= r_state == LATCH;
            case (r_state)
                COUNT: begin
                    r_gate <= r_gate + 1'b1;
                    if (w_edge_p) begin
                        r_edges <= (r_edges == COUNT_MAX) ? r_edges : r_edges + 1'b1;
                        r_sat   <= r_sat | (r_edges == COUNT_MAX);
                    end
                end
                LATCH: begin
                    freq_count <= r_edges;
                    overflow   <= r_sat;
                    r_gate     <= '0;
                    r_edges    <= COUNT_W'(w_edge_p);
                    r_sat      <= 1'b0;
                end
                default: begin
                    r_gate  <= '0;
                    r_edges <= '0;
                    r_sat   <= 1'b0;
                end
            endcase
        end
    end

endmodule
